cail_iic_slave: RTL
===================

CAIL_IIC_SLAVE -- requirements
Module: cail_iic_slave

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h50, giving the 7-bit device address it responds to.
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the memory depth of 2^ADDR_W bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iic_clk, input, 1 bit: I2C SCL driven by the master.
REQ-006 The block SHALL have port iic_sda, inout, 1 bit: I2C SDA, open-drain (drives only 0 or Z; pull-up is external).
REQ-007 The block SHALL have port loc_rd_addr, input, ADDR_W bits: local read address.
REQ-008 The block SHALL have port loc_rd_data, output, 8 bits: memory byte at loc_rd_addr, registered.
REQ-009 The block SHALL have port wr_done, output, 1 bit: one-clk pulse on each byte written to memory.
REQ-010 The block SHALL have port busy, output, 1 bit: high from START until STOP.

Function
REQ-011 iic_clk and iic_sda SHALL be passed through 2-FF synchronizers; edges SHALL be detected on the synchronized values.
REQ-012 START SHALL be SDA falling while SCL is high; STOP SHALL be SDA rising while SCL is high; both SHALL be honoured in any state.
REQ-013 Input bits SHALL be sampled on the SCL rising edge, MSB first; SDA SHALL change only on the clk after an SCL falling edge.
REQ-014 The FSM states SHALL be IDLE, DEV, ACK_DEV, WADDR, ACK_WADDR, WDATA, ACK_WDATA, RDATA, MACK.
- IDLE -> DEV on START.
- DEV: 8 bits shifted; an address match selects ACK_DEV, a mismatch selects IDLE (release SDA).
- ACK_DEV: drive 0 for one SCL pulse; then RDATA if R/W=1, else WADDR.
- WADDR -> ACK_WADDR -> WDATA; the low ADDR_W bits are latched as the pointer and the upper bits are ignored.
- WDATA: each byte is written to mem[pointer], wr_done pulses, the block ACKs, and the pointer increments.
- RDATA: output mem[pointer]; a 1 bit releases SDA, a 0 bit drives low; then MACK.
- MACK: master ACK (0) increments the pointer and returns to RDATA; NACK (1) goes to IDLE and waits for STOP/START.
REQ-015 A repeated START SHALL go to DEV and preserve the pointer, supporting random read.
REQ-016 The pointer SHALL wrap from 2^ADDR_W-1 to 0.
REQ-017 STOP SHALL go to IDLE, release SDA, and drop busy; a partial byte SHALL be discarded.
REQ-018 loc_rd_data SHALL equal mem[loc_rd_addr] one clk after the address is presented; a same-cycle I2C write SHALL be visible one clk later.
REQ-019 The block SHALL not stretch SCL.

Reset
REQ-020 While rst_n=0, the block SHALL hold: FSM=IDLE, SDA released (Z), busy=0, wr_done=0, loc_rd_data=0, pointer=0, synchronizers=1.
REQ-021 Memory contents SHALL NOT be reset.
REQ-022 Reset asserted mid-transfer SHALL release SDA immediately, and the block SHALL ignore the bus until the next START.

Configuration
REQ-023 With IIC_SLAVE_WP_EN defined, the block SHALL add input port wp (1 bit); while wp=1 data bytes in WDATA SHALL be NACKed, SHALL not be written, and SHALL not pulse wr_done, while the address phases still ACK and the pointer still increments.
REQ-024 Without IIC_SLAVE_WP_EN, port wp SHALL not exist and all writes SHALL proceed.

Verification
REQ-025 Byte write: START, A0, 05, 3C, STOP -> three ACKs, mem[5]=8'h3C, one wr_done pulse, loc_rd_addr=5 gives 8'h3C.
REQ-026 Random read: after REQ-025, START, A0, 05, rSTART, A1, read with NACK -> SDA returns 8'h3C, FSM IDLE, busy=0 after STOP.
REQ-027 Page write with wrap: START, A0, 3E, 11, 22, 33, STOP -> mem[62]=8'h11, mem[63]=8'h22, mem[0]=8'h33, three wr_done pulses.
REQ-028 Address mismatch: START, A4 -> no ACK (SDA high on the 9th clock), no memory change, block silent until STOP.
REQ-029 Reset mid-read: rst_n=0 while the block drives a 0 bit -> SDA Z within one clk; the next transaction operates normally.
REQ-030 WP (macro on): wp=1, START, A0, 07, 55, STOP -> the data byte is NACKed, mem[7] is unchanged, and no wr_done pulse occurs.

Source files
------------

// File: rtl/cail_iic_slave.sv
// -----------------------------------------------------------------------------
// cail_iic_slave
//   I2C slave with a small byte-addressed memory (2^ADDR_W bytes).
//   Protocol: [START] dev-addr+R/W, then for writes a pointer byte and
//   data bytes, for reads data bytes returned from the current pointer.
//   A repeated START keeps the pointer, allowing random reads.
//   The pointer wraps at 2^ADDR_W.
//
// Parameters
//   DEV_ADDR    7-bit device address this slave answers to
//   ADDR_W      memory address width (depth = 2^ADDR_W bytes)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   iic_clk      SCL from the master (never stretched)
//   iic_sda      SDA, open drain: driven to 0 or left at Z
//   loc_rd_addr  local read address
//   loc_rd_data  registered memory byte at loc_rd_addr
//   wr_done      one-clk pulse for every byte written to memory
//   busy         high from START until STOP
//   wp           (only with IIC_SLAVE_WP_EN) write protect: data bytes are
//                NACKed and dropped, the pointer still advances
//
// Build option
//   IIC_SLAVE_WP_EN  adds the wp input and write-protect behaviour.
// -----------------------------------------------------------------------------
module cail_iic_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         ADDR_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iic_clk,
   inout  wire               iic_sda,
   input  logic [ADDR_W-1:0] loc_rd_addr,
   output logic [7:0]        loc_rd_data,
   output logic              wr_done,
   output logic              busy
`ifdef IIC_SLAVE_WP_EN
   ,
   input  logic              wp
`endif
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [3:0] {
      IDLE,
      DEV,
      ACK_DEV,
      WADDR,
      ACK_WADDR,
      WDATA,
      ACK_WDATA,
      RDATA,
      MACK
   } state_t;

   // Storage, deliberately not reset
   logic [7:0] mem [0:DEPTH-1];

   // Synchronizers and edge-detect history
   logic scl_s1_q, scl_s1_d;
   logic scl_s2_q, scl_s2_d;
   logic scl_prev_q, scl_prev_d;
   logic sda_s1_q, sda_s1_d;
   logic sda_s2_q, sda_s2_d;
   logic sda_prev_q, sda_prev_d;

   // Protocol state
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [6:0]        sh_q, sh_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              sda_oe_q, sda_oe_d;
   logic              busy_q, busy_d;
   logic              ack_ph_q, ack_ph_d;
   logic              ack_en_q, ack_en_d;
   logic              wr_done_q, wr_done_d;
   logic [7:0]        loc_rd_q, loc_rd_d;

   logic       scl_rise, scl_fall;
   logic       start_det, stop_det;
   logic [7:0] byte_in;
   logic [7:0] mem_rd;
   logic       wr_en;
   logic [7:0] wr_byte;
   logic       wp_act;

`ifdef IIC_SLAVE_WP_EN
   assign wp_act = wp;
`else
   assign wp_act = 1'b0;
`endif

   // Open-drain SDA: only ever pull low
   assign iic_sda = sda_oe_q ? 1'b0 : 1'bz;

   assign busy        = busy_q;
   assign wr_done     = wr_done_q;
   assign loc_rd_data = loc_rd_q;

   // Edge/condition detection on the synchronized bus lines.
   // START/STOP need SCL high on both samples so SCL edges never alias.
   assign scl_rise  =  scl_s2_q & ~scl_prev_q;
   assign scl_fall  = ~scl_s2_q &  scl_prev_q;
   assign start_det =  scl_s2_q &  scl_prev_q &  sda_prev_q & ~sda_s2_q;
   assign stop_det  =  scl_s2_q &  scl_prev_q & ~sda_prev_q &  sda_s2_q;

   // Byte as it stands after the bit currently on the bus is shifted in
   assign byte_in = {sh_q, sda_s2_q};
   assign mem_rd  = mem[ptr_q];

   always_comb begin
      scl_s1_d   = iic_clk;
      scl_s2_d   = scl_s1_q;
      scl_prev_d = scl_s2_q;
      sda_s1_d   = iic_sda;
      sda_s2_d   = sda_s1_q;
      sda_prev_d = sda_s2_q;

      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      rw_d     = rw_q;
      ptr_d    = ptr_q;
      sda_oe_d = sda_oe_q;
      busy_d   = busy_q;
      ack_ph_d = ack_ph_q;
      ack_en_d = ack_en_q;
      wr_en    = 1'b0;
      wr_byte  = byte_in;

      if (start_det) begin
         // Also covers repeated START: the pointer is kept
         state_d  = DEV;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b1;
         ack_ph_d = 1'b0;
      end else if (stop_det) begin
         // Any partial byte is simply dropped
         state_d  = IDLE;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         ack_ph_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               sda_oe_d = 1'b0;
            end

            DEV, WADDR, WDATA: begin
               if (scl_rise) begin
                  sh_d  = byte_in[6:0];
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d    = 4'd0;
                     ack_ph_d = 1'b0;
                     ack_en_d = 1'b1;
                     case (state_q)
                        DEV: begin
                           rw_d = byte_in[0];
                           if (byte_in[7:1] == DEV_ADDR) begin
                              state_d = ACK_DEV;
                           end else begin
                              state_d = IDLE;
                           end
                        end
                        WADDR: begin
                           ptr_d   = byte_in[ADDR_W-1:0];
                           state_d = ACK_WADDR;
                        end
                        default: begin
                           // WDATA: store unless protected; pointer always moves
                           if (wp_act) begin
                              ack_en_d = 1'b0;
                           end else begin
                              wr_en = 1'b1;
                           end
                           ptr_d   = ptr_q + 1'b1;
                           state_d = ACK_WDATA;
                        end
                     endcase
                  end
               end
            end

            ACK_DEV, ACK_WADDR, ACK_WDATA: begin
               // First SCL fall (end of bit 8): present ACK/NACK.
               // Second SCL fall (end of the 9th clock): release and move on.
               if (scl_fall) begin
                  if (!ack_ph_q) begin
                     sda_oe_d = ack_en_q;
                     ack_ph_d = 1'b1;
                  end else begin
                     ack_ph_d = 1'b0;
                     sda_oe_d = 1'b0;
                     cnt_d    = 4'd0;
                     if (state_q == ACK_DEV) begin
                        if (rw_q) begin
                           state_d  = RDATA;
                           sda_oe_d = ~mem_rd[7];
                        end else begin
                           state_d = WADDR;
                        end
                     end else begin
                        state_d = WDATA;
                     end
                  end
               end
            end

            RDATA: begin
               // Bit 7 is already on the bus on entry; cnt counts SCL rises
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end
               if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     cnt_d    = 4'd0;
                     ack_ph_d = 1'b0;
                     state_d  = MACK;
                  end else begin
                     sda_oe_d = ~mem_rd[3'd7 - cnt_q[2:0]];
                  end
               end
            end

            MACK: begin
               if (scl_rise) begin
                  if (sda_s2_q) begin
                     state_d = IDLE;
                  end else begin
                     ack_ph_d = 1'b1;
                     ptr_d    = ptr_q + 1'b1;
                  end
               end else if (scl_fall && ack_ph_q) begin
                  ack_ph_d = 1'b0;
                  cnt_d    = 4'd0;
                  state_d  = RDATA;
                  sda_oe_d = ~mem_rd[7];
               end
            end

            default: begin
               state_d  = IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end

      wr_done_d = wr_en;

      // Bypass so a write in this cycle is seen on the next loc_rd_data
      loc_rd_d = mem[loc_rd_addr];
      if (wr_en && (ptr_q == loc_rd_addr)) begin
         loc_rd_d = wr_byte;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         sh_q       <= 7'd0;
         rw_q       <= 1'b0;
         ptr_q      <= '0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         ack_ph_q   <= 1'b0;
         ack_en_q   <= 1'b0;
         wr_done_q  <= 1'b0;
         loc_rd_q   <= 8'd0;
      end else begin
         scl_s1_q   <= scl_s1_d;
         scl_s2_q   <= scl_s2_d;
         scl_prev_q <= scl_prev_d;
         sda_s1_q   <= sda_s1_d;
         sda_s2_q   <= sda_s2_d;
         sda_prev_q <= sda_prev_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         rw_q       <= rw_d;
         ptr_q      <= ptr_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         ack_ph_q   <= ack_ph_d;
         ack_en_q   <= ack_en_d;
         wr_done_q  <= wr_done_d;
         loc_rd_q   <= loc_rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr_q] <= wr_byte;
      end
   end

endmodule
